data_ram_1r1w_p: RTL and testbench

Parametrised byte-lane 1-read/1-write data RAM for the MA stage, replacing the fixed 4x1024 data RAM. It adds:
- configurable depth, lane count and read latency;
- a read enable with a valid flag;
- write-first forwarding for same-cycle, same-address accesses;
- a post-reset zero-fill state machine.

Optional per-lane parity is available as a compile-time feature.

---
 rtl/data_ram_pkg.sv | 18 +
 rtl/data_ram_lane.sv | 60 ++++++
 rtl/data_ram_1r1w_p.sv | 187 ++++++++++++++++++
 tb/tb_data_ram_1r1w_p.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and constants for the parametrised byte-lane data RAM.
// Optional per-lane parity is enabled by defining DATA_RAM_PARITY_EN.
package data_ram_pkg;

    localparam int unsigned LANE_W       = 8;
    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_t;

    function automatic logic even_parity(input logic [LANE_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/data_ram_lane.sv
// One byte lane: storage array, registered read port and, when
// DATA_RAM_PARITY_EN is defined, a stored even-parity bit per byte.
module data_ram_lane
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wadr,
    input  logic [LANE_W-1:0] wdata,
    input  logic              wpar,
    input  logic              re,
    input  logic [ADDR_W-1:0] radr,
    output logic [LANE_W-1:0] rdata,
    output logic              rpar
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef DATA_RAM_PARITY_EN
    localparam int unsigned CELL_W = LANE_W + 1;
`else
    localparam int unsigned CELL_W = LANE_W;
`endif

    logic [CELL_W-1:0] mem [DEPTH];
    logic [CELL_W-1:0] cell_q;

    always_ff @(posedge clk) begin
        if (we) begin
`ifdef DATA_RAM_PARITY_EN
            mem[wadr] <= {wpar, wdata};
`else
            mem[wadr] <= wdata;
`endif
        end
    end

    // Read register only moves on an accepted read, so it holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            cell_q <= '0;
        end else if (re) begin
            cell_q <= mem[radr];
        end
    end

    assign rdata = cell_q[LANE_W-1:0];

`ifdef DATA_RAM_PARITY_EN
    assign rpar = cell_q[LANE_W];
`else
    logic unused_wpar;
    assign unused_wpar = wpar;
    assign rpar        = 1'b0;
`endif

endmodule

// File: rtl/data_ram_1r1w_p.sv
// Parametrised 1R1W byte-lane data RAM with post-reset zero fill,
// write-first forwarding and READ_LAT of 1 or 2; parity via DATA_RAM_PARITY_EN.
module data_ram_1r1w_p
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned LANES    = 4,
    parameter int unsigned READ_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ram_ren,
    input  logic [ADDR_W-1:0]         ram_radr,
    output logic [LANE_W*LANES-1:0]   ram_rdata,
    output logic                      ram_rvalid,
    input  logic [ADDR_W-1:0]         ram_wadr,
    input  logic [LANE_W*LANES-1:0]   ram_wdata,
    input  logic [LANES-1:0]          ram_wen,
    input  logic                      ram_perr_inj,
    output logic                      init_busy,
    output logic                      ram_perr
);

    localparam int unsigned DW          = LANE_W * LANES;
    localparam bit          EXTRA_STAGE = (READ_LAT > READ_LAT_MIN) && (READ_LAT <= READ_LAT_MAX);

    ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              clearing;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == '1) begin
                state_d = ST_READY;
            end
        end
    end

    assign clearing  = (state_q == ST_CLEAR);
    assign init_busy = clearing;

    // Write port is shared between the zero fill and user writes.
    logic [LANES-1:0]  lane_we;
    logic [ADDR_W-1:0] lane_wadr;
    logic [DW-1:0]     lane_wdata;
    logic [LANES-1:0]  lane_wpar;
    logic [DW-1:0]     lane_rdata;
    logic [LANES-1:0]  lane_rpar;
    logic              rd_acc;

    always_comb begin
        lane_wadr  = clearing ? clr_ptr_q : ram_wadr;
        lane_we    = '0;
        lane_wdata = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_we[i]                    = clearing | ram_wen[i];
            lane_wdata[i*LANE_W +: LANE_W] = clearing ? '0 : ram_wdata[i*LANE_W +: LANE_W];
        end
    end

    assign rd_acc = (state_q == ST_READY) & ram_ren;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        data_ram_lane #(
            .ADDR_W(ADDR_W)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .we   (lane_we[g]),
            .wadr (lane_wadr),
            .wdata(lane_wdata[g*LANE_W +: LANE_W]),
            .wpar (lane_wpar[g]),
            .re   (rd_acc),
            .radr (ram_radr),
            .rdata(lane_rdata[g*LANE_W +: LANE_W]),
            .rpar (lane_rpar[g])
        );
    end

    // Forwarding is resolved after the array read: remember which lanes to override.
    logic             v1_q;
    logic [LANES-1:0] fwd_q;
    logic [DW-1:0]    fdata_q;
    logic [DW-1:0]    data1;
    logic [LANES-1:0] mism1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            fwd_q   <= '0;
            fdata_q <= '0;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                fwd_q   <= ram_wen & {LANES{ram_wadr == ram_radr}};
                fdata_q <= ram_wdata;
            end
        end
    end

    always_comb begin
        data1 = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            data1[i*LANE_W +: LANE_W] = fwd_q[i] ? fdata_q[i*LANE_W +: LANE_W]
                                                 : lane_rdata[i*LANE_W +: LANE_W];
        end
    end

`ifdef DATA_RAM_PARITY_EN
    logic [LANES-1:0] new_par;
    logic [LANES-1:0] fpar_q;
    logic [LANES-1:0] par1;

    always_comb begin
        new_par = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            new_par[i] = even_parity(ram_wdata[i*LANE_W +: LANE_W]) ^ ram_perr_inj;
        end
    end

    assign lane_wpar = clearing ? '0 : new_par;

    always_ff @(posedge clk) begin
        if (rst) begin
            fpar_q <= '0;
        end else if (rd_acc) begin
            fpar_q <= new_par;
        end
    end

    always_comb begin
        par1  = '0;
        mism1 = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            par1[i]  = fwd_q[i] ? fpar_q[i] : lane_rpar[i];
            mism1[i] = even_parity(data1[i*LANE_W +: LANE_W]) ^ par1[i];
        end
    end
`else
    logic unused_par;
    assign unused_par = ^{lane_rpar, ram_perr_inj};
    assign lane_wpar  = '0;
    assign mism1      = '0;
`endif

    if (EXTRA_STAGE) begin : g_lat2
        logic          v2_q;
        logic [DW-1:0] d2_q;
        logic          e2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2_q <= 1'b0;
                d2_q <= '0;
                e2_q <= 1'b0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    d2_q <= data1;
                    e2_q <= |mism1;
                end
            end
        end

        assign ram_rvalid = v2_q;
        assign ram_rdata  = d2_q;
        assign ram_perr   = v2_q & e2_q;
    end else begin : g_lat1
        assign ram_rvalid = v1_q;
        assign ram_rdata  = data1;
        assign ram_perr   = v1_q & (|mism1);
    end

endmodule

// File: tb/tb_data_ram_1r1w_p.sv
// Bench for data_ram_1r1w_p: READ_LAT=1 and READ_LAT=2 instances share stimulus
// and are checked every cycle against a word-level array model.
module tb_data_ram_1r1w_p;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;
    localparam int LANES  = 4;
`ifdef DATA_RAM_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ren;
    logic [ADDR_W-1:0] radr;
    logic [ADDR_W-1:0] wadr;
    logic [31:0]       wdata;
    logic [LANES-1:0]  wen;
    logic              inj;

    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2, perr1, perr2, busy1, busy2;

    data_ram_1r1w_p #(.ADDR_W(ADDR_W), .LANES(LANES), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .ram_ren(ren), .ram_radr(radr),
        .ram_rdata(rdata1), .ram_rvalid(rvalid1), .ram_wadr(wadr),
        .ram_wdata(wdata), .ram_wen(wen), .ram_perr_inj(inj),
        .init_busy(busy1), .ram_perr(perr1)
    );

    data_ram_1r1w_p #(.ADDR_W(ADDR_W), .LANES(LANES), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .ram_ren(ren), .ram_radr(radr),
        .ram_rdata(rdata2), .ram_rvalid(rvalid2), .ram_wadr(wadr),
        .ram_wdata(wdata), .ram_wen(wen), .ram_perr_inj(inj),
        .init_busy(busy2), .ram_perr(perr2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0]      m_mem [DEPTH];
    logic [LANES-1:0] m_bad [DEPTH];
    int               rem;
    bit               v1, v2, e1, e2;
    logic [31:0]      d1, d2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [31:0]      word;
        logic [LANES-1:0] eb;
        if (rst) begin
            rem = DEPTH;
            v1 = 0; v2 = 0; e1 = 0; e2 = 0; d1 = '0; d2 = '0;
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[a] = '0;
                m_bad[a] = '0;
            end
        end else begin
            v2 = v1;
            if (v1) begin
                d2 = d1;
                e2 = e1;
            end
            v1 = 0;
            if (rem == 0) begin
                if (ren) begin
                    word = m_mem[radr];
                    eb   = m_bad[radr];
                    for (int l = 0; l < LANES; l++) begin
                        if (wen[l] && wadr == radr) begin
                            word[8*l +: 8] = wdata[8*l +: 8];
                            eb[l]          = inj;
                        end
                    end
                    v1 = 1;
                    d1 = word;
                    e1 = PAR_EN && (eb != '0);
                end
                for (int l = 0; l < LANES; l++) begin
                    if (wen[l]) begin
                        m_mem[wadr][8*l +: 8] = wdata[8*l +: 8];
                        m_bad[wadr][l]        = inj;
                    end
                end
            end else begin
                rem--;
            end
        end
    endtask

    task automatic check_all();
        chk("busy1",   32'(busy1),   32'(rem != 0));
        chk("busy2",   32'(busy2),   32'(rem != 0));
        chk("rvalid1", 32'(rvalid1), 32'(v1));
        chk("rdata1",  rdata1,       d1);
        chk("perr1",   32'(perr1),   32'(v1 && e1));
        chk("rvalid2", 32'(rvalid2), 32'(v2));
        chk("rdata2",  rdata2,       d2);
        chk("perr2",   32'(perr2),   32'(v2 && e2));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        ren = 1'b0;
        wen = '0;
        inj = 1'b0;
    endtask

    task automatic rand_in(input int unsigned span);
        ren   = 1'($urandom_range(0, 1));
        radr  = ADDR_W'($urandom_range(0, span));
        wadr  = ADDR_W'($urandom_range(0, span));
        wdata = $urandom;
        wen   = LANES'($urandom_range(0, 15));
        inj   = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        bit          any_valid;
        logic [31:0] vals [3];

        rst = 1'b1; idle(); radr = '0; wadr = '0; wdata = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy1), 32'd1);
        chk("rst_rdata", rdata1, 32'd0);

        // Fill after reset, with random traffic that must be dropped
        rst = 1'b0;
        n = 0;
        any_valid = 0;
        while (busy1 && n < DEPTH + 10) begin
            rand_in(DEPTH - 1);
            tick();
            any_valid |= rvalid1 | rvalid2;
            n++;
        end
        chk("fill_len", n, DEPTH);
        chk("fill_no_valid", 32'(any_valid), 32'd0);

        idle(); ren = 1'b1; radr = 10'd5;
        tick();
        chk("first_rd_valid", 32'(rvalid1), 32'd1);
        chk("first_rd_data", rdata1, 32'd0);
        idle();
        tick();

        // Partial-lane overwrite
        wen = 4'b1111; wadr = 10'h3FF; wdata = 32'hDEADBEEF;
        tick();
        wen = 4'b0001; wdata = 32'h000000AA;
        tick();
        idle(); ren = 1'b1; radr = 10'h3FF;
        tick();
        chk("lane_merge1", rdata1, 32'hDEADBEAA);
        idle();
        tick();
        chk("lane_merge2", rdata2, 32'hDEADBEAA);

        // Write-first forwarding on same address
        wen = 4'b1111; wadr = 10'd7; wdata = 32'hAABBCCDD;
        tick();
        wen = 4'b0101; wdata = 32'h11223344; ren = 1'b1; radr = 10'd7;
        tick();
        chk("fwd1", rdata1, 32'hAA22CC44);
        idle();
        tick();
        chk("fwd2", rdata2, 32'hAA22CC44);
        chk("hold_valid1", 32'(rvalid1), 32'd0);
        chk("hold_data1", rdata1, 32'hAA22CC44);

        // Back-to-back reads through the two-stage instance
        vals[0] = 32'h11110001; vals[1] = 32'h22220002; vals[2] = 32'h33330003;
        for (int k = 0; k < 3; k++) begin
            wen = 4'b1111; wadr = ADDR_W'(k + 1); wdata = vals[k];
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 3) begin
                ren = 1'b1; radr = ADDR_W'(k + 1);
            end
            tick();
            if (k >= 1 && k <= 3) begin
                chk("b2b_valid2", 32'(rvalid2), 32'd1);
                chk("b2b_data2", rdata2, vals[k-1]);
            end
            if (k == 4) chk("b2b_end2", 32'(rvalid2), 32'd0);
        end

        // Parity injection, then clean rewrite
        idle(); wen = 4'b0010; wadr = 10'd9; wdata = 32'h00005A00; inj = 1'b1;
        tick();
        idle(); ren = 1'b1; radr = 10'd9;
        tick();
        chk("perr_inj1", 32'(perr1), 32'(PAR_EN));
        idle();
        tick();
        chk("perr_inj2", 32'(perr2), 32'(PAR_EN));
        wen = 4'b0010; wadr = 10'd9; wdata = 32'h00005A00;
        tick();
        idle(); ren = 1'b1; radr = 10'd9;
        tick();
        chk("perr_clean1", 32'(perr1), 32'd0);
        idle();
        tick();
        chk("perr_clean2", 32'(perr2), 32'd0);

        // Random traffic over a small window to exercise forwarding
        for (int k = 0; k < 600; k++) begin
            rand_in(15);
            tick();
        end

        // Reset with a read in flight, then reset again mid-fill
        idle(); ren = 1'b1; radr = 10'd3;
        tick();
        idle(); rst = 1'b1;
        tick();
        chk("inflight_drop2", 32'(rvalid2), 32'd0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            rand_in(DEPTH - 1);
            tick();
        end
        idle(); rst = 1'b1;
        tick();
        rst = 1'b0;
        n = 0;
        any_valid = 0;
        while (busy1 && n < DEPTH + 10) begin
            rand_in(DEPTH - 1);
            tick();
            any_valid |= rvalid1 | rvalid2;
            n++;
        end
        chk("refill_len", n, DEPTH);
        chk("refill_no_valid", 32'(any_valid), 32'd0);

        idle(); ren = 1'b1; radr = 10'd7;
        tick();
        chk("refill_zero", rdata1, 32'd0);
        idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
